// File: rtl/pending_decoder.sv
// Registered pending-bit tracker: binary set/clear indices are decoded into an N-bit bitmap,
// with a popcount, full/empty flags, the last accepted one-hot and a sticky range error.
module pending_decoder #(
  parameter int N    = 8,
  parameter int LogN = (N == 1) ? 0 : $clog2(N) - 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            set_valid,
  output logic            set_ready,
  input  logic [LogN:0]   set_idx,
  input  logic            clear_valid,
  input  logic [LogN:0]   clear_idx,
  input  logic            flush,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    last_onehot,
  output logic [LogN+1:0] count,
  output logic            empty,
  output logic            full,
  output logic            error
);

  localparam logic [LogN+1:0] NCMP = (LogN+2)'(N);

  logic            set_fire;
  logic            set_in_range;
  logic            clear_in_range;
  logic            err_event;
  logic [N-1:0]    set_dec;
  logic [N-1:0]    clear_dec;
  logic [N-1:0]    pending_next;
  logic [N-1:0]    last_next;
  logic [N-1:0]    pending_reg;
  logic [N-1:0]    last_reg;
  logic [LogN+1:0] count_next;
  logic [LogN+1:0] count_reg;
  logic            error_reg;

  assign set_ready      = ~full & ~flush;
  assign set_fire       = set_valid & set_ready;
  assign set_in_range   = {1'b0, set_idx} < NCMP;
  assign clear_in_range = {1'b0, clear_idx} < NCMP;

  // Out-of-range indices never match a decoder row, so they leave the bitmap untouched.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dec
      assign set_dec[gi]   = set_fire & (set_idx == (LogN+1)'(gi));
      assign clear_dec[gi] = clear_valid & (clear_idx == (LogN+1)'(gi));
    end
  endgenerate

  // Clear is applied before set so a same-index collision leaves the bit at 1.
  always_comb begin
    pending_next = '0;
    last_next    = '0;
    if (!flush) begin
      pending_next = (pending_reg & ~clear_dec) | set_dec;
      last_next    = (|set_dec) ? set_dec : last_reg;
    end
    count_next = '0;
    for (int i = 0; i < N; i++) begin
      count_next = count_next + (LogN+2)'(pending_next[i]);
    end
  end

  // A range error on clear is still recorded while flushing; set cannot fire then.
  assign err_event = (set_fire & ~set_in_range) | (clear_valid & ~clear_in_range);

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg <= '0;
      last_reg    <= '0;
      count_reg   <= '0;
      error_reg   <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      last_reg    <= last_next;
      count_reg   <= count_next;
      error_reg   <= error_reg | err_event;
    end
  end

  assign pending     = pending_reg;
  assign last_onehot = last_reg;
  assign count       = count_reg;
  assign error       = error_reg;
  assign empty       = (pending_reg == '0);
  assign full        = &pending_reg;

endmodule
